// File: rtl/laser_pulse_sequencer.sv
// Laser pulse sequencer: shadows pulse timing and drive current, loads the DAC through a
// load/ack handshake, gates the laser in PWM or CW mode. Define SOFT_START_EN for a 16-step DAC ramp.
module laser_pulse_sequencer #(
  parameter int DAC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pulse_width,
  input  logic [23:0] period,
  input  logic [15:0] drive_current,
  input  logic [15:0] drive_current_limit,
  input  logic [15:0] pwm_mon_current_limit,
  input  logic [15:0] cw_mon_current_limit,
  input  logic [15:0] static_control,
  input  logic [15:0] dynamic_control,
  input  logic [15:0] mon_current,
  input  logic        mon_valid,
  output logic [15:0] dac_code,
  output logic        dac_load,
  input  logic        dac_ack,
  output logic        laser_en,
  output logic [7:0]  status
);

  localparam int TO_W = (DAC_TIMEOUT > 1) ? $clog2(DAC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DAC_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DAC_LOAD, S_PULSE, S_GAP, S_CW, S_FAULT} state_t;

  state_t          state_reg, state_next;
  logic [23:0]     cnt_reg, cnt_next;
  logic [23:0]     pw_reg, pw_next;
  logic [23:0]     per_reg, per_next;
  logic [15:0]     cw_cnt_reg, cw_cnt_next;
  logic [15:0]     dac_code_reg, dac_code_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [4:0]      ramp_k_reg, ramp_k_next;
  logic            oneshot_reg, oneshot_next;
  logic            config_err_reg, config_err_next;
  logic            fault_oc_reg, fault_oc_next;
  logic            fault_dac_to_reg, fault_dac_to_next;
  logic            dac_load_reg, dac_load_next;
  logic            laser_en_reg, laser_en_next;
  logic [1:0]      dyn_prev_reg;

  logic        trig_edge, clr_edge, run_en, cw_sel, cfg_bad_pwm;
  logic        oc_trip, disable_req, running, ramp_active;
  logic [15:0] clamped_code, adv_code, oc_limit;
  logic [4:0]  k_adv;
  logic        start_load, abort;
  logic [15:0] load_val;
  logic        unused_ctrl;

`ifdef SOFT_START_EN
  localparam logic [4:0] RAMP_FIRST = 5'd1;
  assign ramp_active = running && (ramp_k_reg != 5'd16);
`else
  // k pinned at 16 makes the scaled code equal the full target.
  localparam logic [4:0] RAMP_FIRST = 5'd16;
  assign ramp_active = 1'b0;
`endif

  function automatic logic [15:0] scale_code(input logic [15:0] target, input logic [4:0] k);
    logic [19:0] prod;
    prod = 20'(target) * 20'(k);
    return prod[19:4];
  endfunction

  assign unused_ctrl  = ^{static_control[15:2], dynamic_control[15:2]};
  assign trig_edge    = dynamic_control[0] & ~dyn_prev_reg[0];
  assign clr_edge     = dynamic_control[1] & ~dyn_prev_reg[1];
  assign run_en       = static_control[0];
  assign cw_sel       = static_control[1];
  assign cfg_bad_pwm  = (period < 24'd2) || (pulse_width >= period);
  assign clamped_code = (drive_current > drive_current_limit) ? drive_current_limit : drive_current;
  assign k_adv        = (ramp_k_reg < 5'd16) ? ramp_k_reg + 5'd1 : ramp_k_reg;
  assign adv_code     = scale_code(clamped_code, k_adv);
  assign oc_limit     = (state_reg == S_CW) ? cw_mon_current_limit : pwm_mon_current_limit;
  assign oc_trip      = mon_valid && ((state_reg == S_PULSE) || (state_reg == S_CW)) &&
                        (mon_current > oc_limit);
  assign disable_req  = !run_en && !oneshot_reg;
  assign running      = (state_reg != S_IDLE) && (state_reg != S_FAULT);

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    pw_next           = pw_reg;
    per_next          = per_reg;
    cw_cnt_next       = cw_cnt_reg;
    dac_code_next     = dac_code_reg;
    to_cnt_next       = to_cnt_reg;
    ramp_k_next       = ramp_k_reg;
    oneshot_next      = oneshot_reg;
    config_err_next   = config_err_reg;
    fault_oc_next     = fault_oc_reg;
    fault_dac_to_next = fault_dac_to_reg;
    dac_load_next     = dac_load_reg;
    laser_en_next     = laser_en_reg;
    start_load        = 1'b0;
    abort             = 1'b0;
    load_val          = dac_code_reg;

    case (state_reg)
      S_IDLE: begin
        if (run_en || trig_edge) begin
          pw_next  = pulse_width;
          per_next = period;
          if (!cw_sel && cfg_bad_pwm) begin
            config_err_next = 1'b1;
          end else begin
            config_err_next = 1'b0;
            oneshot_next    = !run_en;
            ramp_k_next     = RAMP_FIRST;
            start_load      = 1'b1;
            load_val        = scale_code(clamped_code, RAMP_FIRST);
          end
        end
      end
      S_DAC_LOAD: begin
        if (disable_req) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end else if (dac_ack) begin
          dac_load_next = 1'b0;
          cnt_next      = '0;
          cw_cnt_next   = '0;
          if (cw_sel) begin
            state_next    = S_CW;
            laser_en_next = 1'b1;
          end else if (pw_reg != 24'd0) begin
            state_next    = S_PULSE;
            laser_en_next = 1'b1;
          end else begin
            state_next = S_GAP;
          end
        end else if (to_cnt_reg == TO_LAST) begin
          fault_dac_to_next = 1'b1;
          state_next        = S_FAULT;
          abort             = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_PULSE, S_GAP: begin
        if (oc_trip) begin
          fault_oc_next = 1'b1;
          state_next    = S_FAULT;
          abort         = 1'b1;
        end else if (disable_req) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end else if (cnt_reg == per_reg - 24'd1) begin
          if (oneshot_reg) begin
            state_next = S_IDLE;
            abort      = 1'b1;
          end else if (cfg_bad_pwm) begin
            config_err_next = 1'b1;
            state_next      = S_IDLE;
            abort           = 1'b1;
          end else begin
            pw_next     = pulse_width;
            per_next    = period;
            ramp_k_next = k_adv;
            if (adv_code != dac_code_reg) begin
              start_load = 1'b1;
              load_val   = adv_code;
            end else begin
              cnt_next      = '0;
              state_next    = (pulse_width != 24'd0) ? S_PULSE : S_GAP;
              laser_en_next = (pulse_width != 24'd0);
            end
          end
        end else begin
          cnt_next = cnt_reg + 24'd1;
          if (cnt_reg + 24'd1 < pw_reg) begin
            state_next    = S_PULSE;
            laser_en_next = 1'b1;
          end else begin
            state_next    = S_GAP;
            laser_en_next = 1'b0;
          end
        end
      end
      S_CW: begin
        if (oc_trip) begin
          fault_oc_next = 1'b1;
          state_next    = S_FAULT;
          abort         = 1'b1;
        end else if (disable_req) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end else if (cw_cnt_reg == 16'hFFFF) begin
          // Counter wraps to 0 here, giving one re-latch every 2^16 cycles.
          cw_cnt_next = '0;
          ramp_k_next = k_adv;
          if (adv_code != dac_code_reg) begin
            start_load = 1'b1;
            load_val   = adv_code;
          end
        end else begin
          cw_cnt_next = cw_cnt_reg + 16'd1;
        end
      end
      S_FAULT: begin
        if (clr_edge && !run_en) begin
          state_next        = S_IDLE;
          fault_oc_next     = 1'b0;
          fault_dac_to_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      ramp_k_next   = RAMP_FIRST;
      dac_load_next = 1'b0;
      laser_en_next = 1'b0;
      oneshot_next  = 1'b0;
    end
    if (start_load) begin
      state_next    = S_DAC_LOAD;
      dac_load_next = 1'b1;
      dac_code_next = load_val;
      to_cnt_next   = '0;
      laser_en_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      pw_reg           <= '0;
      per_reg          <= '0;
      cw_cnt_reg       <= '0;
      dac_code_reg     <= '0;
      to_cnt_reg       <= '0;
      ramp_k_reg       <= RAMP_FIRST;
      oneshot_reg      <= 1'b0;
      config_err_reg   <= 1'b0;
      fault_oc_reg     <= 1'b0;
      fault_dac_to_reg <= 1'b0;
      dac_load_reg     <= 1'b0;
      laser_en_reg     <= 1'b0;
      dyn_prev_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      pw_reg           <= pw_next;
      per_reg          <= per_next;
      cw_cnt_reg       <= cw_cnt_next;
      dac_code_reg     <= dac_code_next;
      to_cnt_reg       <= to_cnt_next;
      ramp_k_reg       <= ramp_k_next;
      oneshot_reg      <= oneshot_next;
      config_err_reg   <= config_err_next;
      fault_oc_reg     <= fault_oc_next;
      fault_dac_to_reg <= fault_dac_to_next;
      dac_load_reg     <= dac_load_next;
      laser_en_reg     <= laser_en_next;
      dyn_prev_reg     <= dynamic_control[1:0];
    end
  end

  assign dac_code = dac_code_reg;
  assign dac_load = dac_load_reg;
  assign laser_en = laser_en_reg;
  assign status   = {laser_en_reg, dac_load_reg, ramp_active, config_err_reg,
                     fault_dac_to_reg, fault_oc_reg, (state_reg == S_CW), running};

endmodule

// File: tb/tb_laser_pulse_sequencer.sv
// Self-checking bench for laser_pulse_sequencer: randomized PWM runs against a duty/clamp model,
// plus overcurrent, DAC timeout, config error, single shot, reload, CW and async reset cases.
module tb_laser_pulse_sequencer;

  localparam int DAC_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pulse_width = '0;
  logic [23:0] period = '0;
  logic [15:0] drive_current = '0;
  logic [15:0] drive_current_limit = '0;
  logic [15:0] pwm_mon_current_limit = 16'hFFFF;
  logic [15:0] cw_mon_current_limit = 16'hFFFF;
  logic [15:0] static_control = '0;
  logic [15:0] dynamic_control = '0;
  logic [15:0] mon_current = '0;
  logic        mon_valid = 1'b0;
  logic [15:0] dac_code;
  logic        dac_load;
  logic        dac_ack = 1'b0;
  logic        laser_en;
  logic [7:0]  status;

  int checks = 0;
  int failures = 0;
  int ack_delay = 3;     // dac_load cycles before ack; negative means never ack
  int load_cycles = 0;
  logic load_prev = 1'b0;
  logic [15:0] load_q[$];

  always #5 clk = ~clk;

  laser_pulse_sequencer #(.DAC_TIMEOUT(DAC_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pulse_width(pulse_width), .period(period),
    .drive_current(drive_current), .drive_current_limit(drive_current_limit),
    .pwm_mon_current_limit(pwm_mon_current_limit), .cw_mon_current_limit(cw_mon_current_limit),
    .static_control(static_control), .dynamic_control(dynamic_control),
    .mon_current(mon_current), .mon_valid(mon_valid), .dac_code(dac_code),
    .dac_load(dac_load), .dac_ack(dac_ack), .laser_en(laser_en), .status(status)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock; sample just after the edge, record DAC loads and play the DAC side of the handshake.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dac_load && !load_prev) load_q.push_back(dac_code);
    load_prev = dac_load;
    if (dac_load && !dac_ack) begin
      load_cycles++;
      if (ack_delay >= 0 && load_cycles >= ack_delay) dac_ack = 1'b1;
    end else begin
      dac_ack = 1'b0;
      load_cycles = 0;
    end
  endtask

  task automatic wait_load(input logic level, input int bound, input string tag);
    int n = 0;
    while (dac_load !== level && n < bound) begin
      tick();
      n++;
    end
    check_val(tag, dac_load, level);
  endtask

  task automatic pulse_dyn(input logic [15:0] val);
    dynamic_control = val;
    tick();
    dynamic_control = '0;
  endtask

  task automatic start_cont(input logic [23:0] pw, input logic [23:0] per, input logic [15:0] ctrl);
    pulse_width = pw;
    period = per;
    drive_current = 16'h1000;
    drive_current_limit = 16'h3F00;
    static_control = ctrl;
    tick();
    wait_load(1'b0, 20, "start_ack");
  endtask

  task automatic run_pwm(input logic [23:0] pw, input logic [23:0] per, input logic [15:0] dc,
                         input logic [15:0] lim, input int delay);
    int highs = 0;
    int win;
    logic [15:0] exp_code;
    exp_code = (dc < lim) ? dc : lim;
    pulse_width = pw;
    period = per;
    drive_current = dc;
    drive_current_limit = lim;
    ack_delay = delay;
    load_q.delete();
    static_control = 16'h0001;
    tick();
    check_val("start_latency", dac_load, 1);
    check_val("dac_code", dac_code, exp_code);
    wait_load(1'b0, 20, "ack_wait");
    check_val("first_laser", laser_en, pw != 0);
    win = (int'(per) > 1000) ? 1 : 2;
    for (int i = 0; i < win * int'(per); i++) begin
      highs += int'(laser_en);
      tick();
    end
    check_val("duty", highs, win * int'(pw));
    check_val("load_count", load_q.size(), 1);
    check_val("running", status[0], 1);
    static_control = '0;
    tick();
    check_val("disable", {status[0], laser_en}, 2'b00);
    $display("txn pwm pw=%0d per=%0d code=0x%0h ack=%0d highs=%0d", pw, per, exp_code, delay, highs);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs;
    int act;
    logic [23:0] rper;
    logic [23:0] rpw;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {dac_code, dac_load, laser_en, status}, 0);
    rst = 1'b0;
    tick();
    $display("txn reset");

    // PWM runs: the two fixed cases first, then random timing/current.
    run_pwm(24'h99, 24'h3E00, 16'h3600, 16'h3F00, 3);
    run_pwm(24'd4, 24'd12, 16'h4000, 16'h3F00, 2);
    for (int it = 0; it < 8; it++) begin
      rper = 24'($urandom_range(40, 2));
      rpw  = 24'($urandom_range(int'(rper) - 1, 0));
      run_pwm(rpw, rper, 16'($urandom), 16'($urandom), int'($urandom_range(5, 1)));
    end

    // Code change mid-run reloads the DAC at period end with the laser off.
    ack_delay = 2;
    start_cont(24'd4, 24'd10, 16'h0001);
    drive_current = 16'h0200;
    load_q.delete();
    wait_load(1'b1, 15, "reload_wait");
    check_val("reload_code", dac_code, 16'h0200);
    check_val("reload_laser_off", laser_en, 0);
    wait_load(1'b0, 10, "reload_ack");
    check_val("reload_resume", laser_en, 1);
    static_control = '0;
    tick();
    $display("txn reload code=0x200");

    // PWM overcurrent: equal is fine, one above trips within a cycle.
    pwm_mon_current_limit = 16'h00B0;
    ack_delay = 1;
    start_cont(24'd10, 24'd30, 16'h0001);
    tick();
    mon_current = 16'h00B0;
    mon_valid = 1'b1;
    tick();
    check_val("oc_equal", {laser_en, status[2]}, 2'b10);
    mon_current = 16'h00B1;
    tick();
    mon_valid = 1'b0;
    check_val("oc_laser_off", laser_en, 0);
    check_val("oc_flag", status[2], 1);
    check_val("oc_not_running", status[0], 0);
    pulse_dyn(16'h0002);
    tick();
    check_val("clr_while_enabled", status[2], 1);
    static_control = '0;
    tick();
    pulse_dyn(16'h0002);
    check_val("clr_after_disable", {status[2], status[0]}, 2'b00);
    $display("txn overcurrent pwm");

    // Overcurrent samples during GAP are ignored.
    start_cont(24'd3, 24'd20, 16'h0001);
    repeat (5) tick();
    mon_current = 16'hFFFF;
    mon_valid = 1'b1;
    tick();
    mon_valid = 1'b0;
    check_val("gap_oc_ignored", {status[2], status[0]}, 2'b01);
    static_control = '0;
    tick();
    $display("txn gap overcurrent ignored");

    // CW mode uses the CW limit.
    cw_mon_current_limit = 16'h0200;
    start_cont(24'd3, 24'd20, 16'h0003);
    check_val("cw_status", {laser_en, status[1], status[0]}, 3'b111);
    mon_current = 16'h01FF;
    mon_valid = 1'b1;
    tick();
    check_val("cw_below_limit", {laser_en, status[2]}, 2'b10);
    mon_current = 16'h0201;
    tick();
    mon_valid = 1'b0;
    check_val("cw_oc", {laser_en, status[2]}, 2'b01);
    static_control = '0;
    tick();
    pulse_dyn(16'h0002);
    check_val("cw_clr", status[2], 0);
    $display("txn overcurrent cw");

    // DAC never acks: timeout fault after DAC_TIMEOUT load cycles.
    ack_delay = -1;
    pulse_width = 24'd5;
    period = 24'd20;
    static_control = 16'h0001;
    tick();
    n = 0;
    while (dac_load && n < 400) begin
      n++;
      tick();
    end
    check_val("timeout_cycles", n, DAC_TIMEOUT);
    check_val("timeout_flag", {status[3], dac_load}, 2'b10);
    static_control = '0;
    tick();
    pulse_dyn(16'h0002);
    check_val("timeout_clr", status[3], 0);
    ack_delay = 2;
    $display("txn dac timeout cycles=%0d", n);

    // Bad config: laser never fires; a good config clears the flag on start.
    pulse_width = 24'h10;
    period = 24'h10;
    static_control = 16'h0001;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      act += int'(laser_en) + int'(dac_load);
    end
    check_val("cfg_no_activity", act, 0);
    check_val("cfg_err_flag", status[4], 1);
    pulse_width = 24'd5;
    tick();
    check_val("cfg_err_cleared", {status[4], dac_load}, 2'b01);
    wait_load(1'b0, 10, "cfg_ack");
    static_control = '0;
    tick();
    $display("txn config error");

    // Single shot: one pulse of pw cycles, then IDLE.
    pulse_width = 24'd5;
    period = 24'h20;
    load_q.delete();
    pulse_dyn(16'h0001);
    check_val("ss_start", dac_load, 1);
    highs = 0;
    for (int i = 0; i < 80; i++) begin
      highs += int'(laser_en);
      tick();
    end
    check_val("ss_pulse_len", highs, 5);
    check_val("ss_idle", status[0], 0);
    check_val("ss_loads", load_q.size(), 1);
    $display("txn single shot highs=%0d", highs);

    // Async reset mid-pulse drops the laser before the next clock edge.
    start_cont(24'd8, 24'd16, 16'h0001);
    tick();
    check_val("pre_reset_laser", laser_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_reset", {laser_en, status}, 0);
    static_control = '0;
    tick();
    rst = 1'b0;
    tick();
    check_val("post_reset_idle", status, 0);
    $display("txn async reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_pulse_sequencer.md
# laser_pulse_sequencer

Sequences the laser driver from the I2C register-file outputs. It latches the pulse timing and the drive current into shadow registers, then loads the clamped current code into the DAC through a handshake. It generates the PWM or CW laser enable and trips to a latched fault on monitor overcurrent or on a DAC handshake timeout. It sits between the register block and the DAC/laser-gate pins and drives the 8-bit `status` readback.

## Interface
Parameters:
- `DAC_TIMEOUT`, 255: cycles to wait for `dac_ack` before faulting.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pulse_width`  in  24  laser-on cycles per period.
- `period`  in  24  period length in cycles.
- `drive_current`  in  16  requested DAC code.
- `drive_current_limit`  in  16  DAC code ceiling.
- `pwm_mon_current_limit`  in  16  overcurrent threshold in PWM mode.
- `cw_mon_current_limit`  in  16  overcurrent threshold in CW mode.
- `static_control`  in  16  bit0 = run enable, bit1 = CW mode; other bits ignored.
- `dynamic_control`  in  16  self-clearing pulse; bit0 = single-shot trigger, bit1 = fault clear.
- `mon_current`  in  16  monitor ADC sample.
- `mon_valid`  in  1  `mon_current` valid strobe.
- `dac_code`  out  16  DAC code.
- `dac_load`  out  1  DAC load request; held until acknowledged.
- `dac_ack`  in  1  DAC load done.
- `laser_en`  out  1  laser gate (registered).
- `status`  out  8  {pulse_phase, dac_busy, ramp_active, config_err, fault_dac_to, fault_oc, cw, running}.

## Operation
- States: IDLE, DAC_LOAD, PULSE, GAP, CW, FAULT. All outputs reset to 0 and the state resets to IDLE.
- Edge detection: bit0 and bit1 of `dynamic_control` are rising-edge detected, so one event is generated per register-block pulse.

IDLE:
- Starts on `static_control[0]` = 1 (continuous) or on a bit0 edge (single shot).
- On start, latches the shadows: `pw`, `per`, and `code = min(drive_current, drive_current_limit)`. A single shot also sets the `oneshot` flag.
- Config check (PWM only): if `per` < 2 or `pw` >= `per`, set `config_err` and stay in IDLE.
- `config_err` clears on the next accepted start.

DAC_LOAD:
- `dac_code` = shadow code and `dac_load` = 1.
- On `dac_ack` = 1, drop `dac_load` and go to CW if `static_control[1]`, else PULSE.
- If no ack within `DAC_TIMEOUT` cycles, set `fault_dac_to` and go to FAULT.

PULSE / GAP:
- A 24-bit counter `cnt` starts at 0.
- `laser_en` = 1 while `cnt` < `pw` (PULSE); GAP follows for the rest of the period. `pw` = 0 goes straight to GAP.
- When `cnt` = `per`-1:
  - If `oneshot` → IDLE.
  - Else re-latch the shadows and re-check the config; an error sets `config_err` and goes to IDLE.
  - If the new code differs from `dac_code` → DAC_LOAD, otherwise → PULSE with `cnt` = 0.

CW:
- `laser_en` = 1 continuously; the new code is re-latched every 2^16 cycles, with reload as above.

Overcurrent:
- Trips when `mon_valid` and `mon_current` > limit during PULSE or CW. The limit is the CW limit in CW, else the PWM limit.
- Sets `fault_oc` and goes to FAULT.
- Samples taken in GAP are ignored.

FAULT:
- `laser_en` = 0 and `dac_load` = 0.
- Exits to IDLE on a bit1 edge only while `static_control[0]` = 0; this clears `fault_oc` and `fault_dac_to`.

Disable:
- `static_control[0]` going to 0 in DAC_LOAD, PULSE, GAP or CW → IDLE immediately.
- A single shot ignores this bit.

Simultaneous events:
- Overcurrent beats period end.
- Disable beats period end.
- Fault clear while still enabled is ignored.

`status` bits:
- `running` = state ∉ {IDLE, FAULT}.
- `cw` = state is CW.
- `dac_busy` = `dac_load`.
- `pulse_phase` = `laser_en`.

## Timing
- Start condition sampled at edge N → `dac_load` = 1 from N+1.
- Ack sampled at edge M → `laser_en` = 1 from M+1.
- Without a DAC reload, `laser_en` is high for exactly `pw` cycles every `per` cycles.
- A reload stretches that period's GAP by the handshake length (`dac_load` high for at least 1 cycle).
- Overcurrent sample at edge K → `laser_en` = 0 from K+1 (one-cycle reaction).
- `rst` asserted mid-pulse → `laser_en` = 0 asynchronously.

## Configuration
- `SOFT_START_EN` defined:
  - On each start from IDLE, the DAC code ramps as `code_k = (target*k)>>4` for k = 1..16.
  - k advances at each period end (PWM) or each CW re-latch, with a DAC_LOAD per step.
  - `ramp_active` = 1 until k = 16.
  - A fault or disable aborts the ramp and resets k to 1.
- `SOFT_START_EN` undefined:
  - Full `target` is loaded immediately and `ramp_active` stays 0.

## Test plan
- Ack after 3 cycles, then continuous run: `pulse_width`=0x99, `period`=0x3E00, `drive_current`=0x3600, limit 0x3F00, `static_control`=1 → one `dac_load` with `dac_code`=0x3600; `laser_en` high for 153 of every 15872 cycles; `status[0]`=1.
- `drive_current`=0x4000, limit 0x3F00 → `dac_code`=0x3F00.
- `mon_current`=0x00B1 with `mon_valid` during PULSE, PWM limit 0x00B0 → `laser_en` low on the next cycle and `status[2]`=1. A fault-clear edge while enabled is ignored; after disable, a clear edge returns to IDLE.
- `dac_ack` tied low → after 255 cycles `status[3]`=1 and `dac_load`=0.
- `period`=0x10, `pulse_width`=0x10 → `config_err`=1 and `laser_en` never asserts.
- Single-shot edge with `period`=0x20, `pulse_width`=5 → exactly one 5-cycle pulse, then IDLE. With `SOFT_START_EN` defined and `static_control`=1, target 0x3600 → first `dac_code`=0x0360, then 0x06C0, …, 0x3600.
